// File: rtl/ula_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ula_timing_pkg
//  Description : Shared ULA video timing constants (line/frame geometry,
//                sync, blanking and frame interrupt windows).
//  Revision    : 1.0 - initial release
// ============================================================================
package ula_timing_pkg;

    // Counter widths
    localparam int HC_W    = 10;
    localparam int VC_W    = 9;
    localparam int FRAME_W = 5;

    // Horizontal geometry, in pixel clocks
    localparam logic [HC_W-1:0] H_TOTAL    = 10'd912;
    localparam logic [HC_W-1:0] H_PAPER    = 10'd512;
    localparam logic [HC_W-1:0] HBLK_START = 10'd640;
    localparam logic [HC_W-1:0] HBLK_END   = 10'd831;
    localparam logic [HC_W-1:0] HS_START   = 10'd688;
    localparam logic [HC_W-1:0] HS_END     = 10'd751;

    // Vertical geometry, in lines
    localparam logic [VC_W-1:0] V_TOTAL    = 9'd312;
    localparam logic [VC_W-1:0] V_PAPER    = 9'd192;
    localparam logic [VC_W-1:0] VS_START   = 9'd248;
    localparam logic [VC_W-1:0] VS_END     = 9'd251;

    // Z80 frame interrupt window
    localparam logic [VC_W-1:0] INT_LINE   = 9'd248;
    localparam logic [HC_W-1:0] INT_HSTART = 10'd0;
    localparam logic [HC_W-1:0] INT_LEN    = 10'd128;

endpackage : ula_timing_pkg
`default_nettype wire

// File: rtl/ula_vcounter.sv
`default_nettype none
// ============================================================================
//  Module      : ula_vcounter
//  Description : Line counter (0..V_TOTAL-1) and 5-bit frame counter,
//                advanced by the end-of-line strobe from the horizontal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_vcounter
    import ula_timing_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               line_end,
    output logic [VC_W-1:0]    vc,
    output logic [FRAME_W-1:0] frame_cnt
);

    logic [VC_W-1:0]    r_vc;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               w_last_line;

    assign w_last_line = (r_vc == V_TOTAL - 9'd1);

    // Advance the line on every end-of-line strobe; bump the frame on line wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vc        <= '0;
            r_frame_cnt <= '0;
        end else if (line_end) begin
            if (w_last_line) begin
                r_vc        <= '0;
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end else begin
                r_vc        <= r_vc + 9'd1;
            end
        end
    end

    assign vc        = r_vc;
    assign frame_cnt = r_frame_cnt;

endmodule : ula_vcounter
`default_nettype wire

// File: rtl/ula_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ula_sync_gen
//  Description : ULA video timing stage. Tracks line/frame count from the
//                free-running horizontal count and produces registered
//                sync, blanking, paper enable, frame INT and FLASH phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_sync_gen
    import ula_timing_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            paper_en,
    output logic            blank_n,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            csync_n,
    output logic            int_n,
    output logic            flash
);

    logic [FRAME_W-1:0] w_frame_cnt;
    logic               w_hc_valid;
    logic               w_line_end;
    logic               w_paper;
    logic               w_hblank;
    logic               w_vblank;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_blank_n;
    logic               w_int_act;
    logic               w_unused_frame;

    logic               r_paper_en;
    logic               r_blank_n;
    logic               r_hsync_n;
    logic               r_vsync_n;
    logic               r_csync_n;
    logic               r_int_n;

    // An out-of-range hc neither advances the line nor drives any active output
    assign w_hc_valid = (hc < H_TOTAL);
    assign w_line_end = (hc == H_TOTAL - 10'd1);

    ula_vcounter u_vcounter (
        .clock     (clock),
        .reset_n   (reset_n),
        .line_end  (w_line_end),
        .vc        (vc),
        .frame_cnt (w_frame_cnt)
    );

    // Decode uses vc before its update so each hc/vc pair stays consistent
    always_comb begin
        w_hblank  = (hc >= HBLK_START) && (hc <= HBLK_END);
        w_vblank  = (vc >= VS_START)   && (vc <= VS_END);
        w_paper   = w_hc_valid && (hc < H_PAPER) && (vc < V_PAPER);
        w_hs_act  = w_hc_valid && (hc >= HS_START) && (hc <= HS_END);
        w_vs_act  = w_hc_valid && w_vblank;
        w_blank_n = w_hc_valid && !(w_hblank || w_vblank);
        // Offset form keeps the window test unsigned without a constant-true compare
        w_int_act = w_hc_valid && (vc == INT_LINE) && ((hc - INT_HSTART) < INT_LEN);
    end

    // Register the decoded timing outputs (one clock of latency)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_paper_en <= 1'b0;
            r_blank_n  <= 1'b0;
            r_hsync_n  <= 1'b1;
            r_vsync_n  <= 1'b1;
            r_csync_n  <= 1'b1;
            r_int_n    <= 1'b1;
        end else begin
            r_paper_en <= w_paper;
            r_blank_n  <= w_blank_n;
            r_hsync_n  <= !w_hs_act;
            r_vsync_n  <= !w_vs_act;
            r_csync_n  <= !(w_hs_act || w_vs_act);
            r_int_n    <= !w_int_act;
        end
    end

    // Only the top frame bit is needed here: FLASH flips every 16 frames
    assign w_unused_frame = &{1'b0, w_frame_cnt[FRAME_W-2:0]};

    assign paper_en = r_paper_en;
    assign blank_n  = r_blank_n;
    assign hsync_n  = r_hsync_n;
    assign vsync_n  = r_vsync_n;
    assign csync_n  = r_csync_n;
    assign int_n    = r_int_n;
    assign flash    = w_frame_cnt[FRAME_W-1];

endmodule : ula_sync_gen
`default_nettype wire
